seq_alu: RTL
============

Name: seq_alu

Overview:
- Multi-cycle 16-bit integer ALU. It is the responder side of the control unit's go/op/a/b → out/done handshake.
- Accepts one operation per go, computes it, and returns a result with a one-cycle done pulse and an error flag.
- Simple ops complete in one cycle. MUL uses iterative shift-add; DIV/MOD use iterative restoring division.

Parameters:
- WIDTH, 16, data width of alu_a, alu_b and alu_out. Iteration count equals WIDTH.
- OP_WIDTH, 16, width of alu_op. Only alu_op[3:0] is decoded; any nonzero upper bit makes the op illegal.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- alu_go  input  1  request strobe, sampled only in IDLE.
- alu_op  input  OP_WIDTH  opcode.
- alu_a  input  WIDTH  operand A (signed two's complement).
- alu_b  input  WIDTH  operand B.
- alu_out  output  WIDTH  result, registered.
- alu_done  output  1  one-cycle completion pulse.
- alu_err  output  1  error flag, valid while alu_done=1, otherwise 0.

Behaviour:
- Reset (reset_n=0 at a rising edge): state IDLE, alu_out=0, alu_done=0, alu_err=0, iteration counter and working registers cleared. Reset aborts any op in progress; no done is produced for it.
- States: IDLE, MUL, DIV, FIX.
- Accept: rising edge with state IDLE and alu_go=1 (edge N). op, a and b are latched at edge N. Later changes to the inputs have no effect.
- alu_go while not IDLE is ignored. It is not queued.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 NOT(a), 9 EQ, 10 LT signed, 11 SHL, 12 SHR logical. Opcodes 13-15 and any nonzero alu_op[15:4] are illegal.
- Single-cycle ops (0,1,5-12), illegal ops, and DIV/MOD with b=0:
  - alu_out and alu_done=1 are registered at edge N, so they are visible in cycle N+1. State stays IDLE.
- ADD/SUB/MUL wrap modulo 2^WIDTH with no error.
- EQ and LT return 1 or 0.
- SHL/SHR use shift amount b[3:0]. If b[15:4] is nonzero, the result is 0.
- MUL:
  - IDLE→MUL at edge N.
  - 16 iterations on edges N+1..N+16. The low 16 bits of the product are registered with done at edge N+16.
  - Then MUL→IDLE.
- DIV/MOD:
  - IDLE→DIV at edge N; operand magnitudes are captured.
  - 16 restoring iterations on edges N+1..N+16.
  - DIV→FIX at N+16. Sign fixup registers the result with done at edge N+17, then FIX→IDLE.
  - Quotient truncates toward zero. Remainder takes the dividend's sign.
  - 0x8000 / 0xFFFF gives quotient 0x8000, remainder 0, no error.
- Errors (illegal op, or DIV/MOD with b=0): alu_out=0, alu_err=1, alu_done=1, all single-cycle.
- alu_done is high for exactly one cycle.
- alu_out holds its value until the next result is registered.
- alu_err drops to 0 the cycle after done.
- Back-to-back: in the cycle alu_done=1 the state is IDLE, so a go sampled at that edge is accepted.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: DIV/MOD datapath, DIV/FIX states and the b=0 check behave as above.
- Undefined: no divider logic is built. Opcodes 3 and 4 are illegal: single-cycle, alu_out=0, alu_err=1.

Test Plan:
- Reset, then ADD a=0x7FFF b=0x0001 → done in cycle N+1, out=0x8000, err=0. Then SUB a=0x0000 b=0x0001 → out=0xFFFF.
- MUL a=300 b=300 → done exactly at edge N+16 (not before), out=0x5F90, err=0. Then MUL a=0xFFFF b=0x0003 → out=0xFFFD.
- DIV a=0xFFF9 (-7) b=2 → done at N+17, out=0xFFFD. MOD with the same operands → out=0xFFFF. DIV a=0x8000 b=0xFFFF → out=0x8000, err=0.
- DIV a=5 b=0 → done at N+1, out=0, err=1. alu_op=0x0010 → err=1, out=0. SHL a=1 b=0x0010 → out=0, err=0.
- Start MUL, hold alu_go=1 with changed operands throughout → only one done, result from the original operands. Issue ADD in the done cycle → accepted, done one cycle later.
- Start DIV, pull reset_n low at edge N+5 → no done, out=0, state IDLE. Next ADD 2+3 → out=5.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle 16-bit ALU with shift-add multiply and restoring divide.
// Define SEQ_ALU_DIV_EN to build the DIV/MOD datapath; otherwise opcodes 3/4 are illegal.
`default_nettype none

module seq_alu #(
    parameter int WIDTH    = 16,
    parameter int OP_WIDTH = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                alu_go,
    input  logic [OP_WIDTH-1:0] alu_op,
    input  logic [WIDTH-1:0]    alu_a,
    input  logic [WIDTH-1:0]    alu_b,
    output logic [WIDTH-1:0]    alu_out,
    output logic                alu_done,
    output logic                alu_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
`endif
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_EQ  = 4'd9;
    localparam logic [3:0] OP_LT  = 4'd10;
    localparam logic [3:0] OP_SHL = 4'd11;
    localparam logic [3:0] OP_SHR = 4'd12;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state, next_state;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_lo;
    logic             op_hi_set;
    logic             start_mul, start_div, single_take;
    logic [WIDTH-1:0] single_res;
    logic             single_err;
    logic             shift_big;

    logic [WIDTH-1:0] mcand, mplier, acc, mul_sum;

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0] rem, dq, dvs, rem_n, dq_n, a_mag, b_mag, fix_res;
    logic [WIDTH:0]   shifted, trial;
    logic             neg_q, neg_r, is_mod, ge;
`endif

    assign op_lo     = alu_op[3:0];
    assign op_hi_set = |alu_op[OP_WIDTH-1:4];
    assign shift_big = |alu_b[WIDTH-1:4];
    assign start_mul = !op_hi_set && (op_lo == OP_MUL);
`ifdef SEQ_ALU_DIV_EN
    assign start_div = !op_hi_set && ((op_lo == OP_DIV) || (op_lo == OP_MOD)) && (alu_b != '0);
`else
    assign start_div = 1'b0;
`endif
    assign single_take = !start_mul && !start_div;

    assign mul_sum = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_ALU_DIV_EN
    assign a_mag   = alu_a[WIDTH-1] ? -alu_a : alu_a;
    assign b_mag   = alu_b[WIDTH-1] ? -alu_b : alu_b;
    // Restoring step: shift in the next dividend bit, keep the subtraction only if it did not borrow.
    assign shifted = {rem, dq[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign ge      = !trial[WIDTH];
    assign rem_n   = ge ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dq[WIDTH-1]};
    assign dq_n    = {dq[WIDTH-2:0], ge};
    assign fix_res = is_mod ? (neg_r ? -rem : rem) : (neg_q ? -dq : dq);
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (alu_go && start_mul) begin
                    next_state = S_MUL;
                end else if (alu_go && start_div) begin
                    next_state = S_DIV;
                end
            end
            S_MUL: begin
                if (cnt == LAST) begin
                    next_state = S_IDLE;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            S_DIV: begin
                if (cnt == LAST) begin
                    next_state = S_FIX;
                end
            end
            S_FIX:   next_state = S_IDLE;
`else
            S_DIV, S_FIX: next_state = S_IDLE;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Result of anything that finishes on the accepting edge, including all error cases.
    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        if (op_hi_set) begin
            single_err = 1'b1;
        end else begin
            case (op_lo)
                OP_ADD: single_res = alu_a + alu_b;
                OP_SUB: single_res = alu_a - alu_b;
                OP_AND: single_res = alu_a & alu_b;
                OP_OR:  single_res = alu_a | alu_b;
                OP_XOR: single_res = alu_a ^ alu_b;
                OP_NOT: single_res = ~alu_a;
                OP_EQ:  single_res = {{(WIDTH-1){1'b0}}, (alu_a == alu_b)};
                OP_LT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
                OP_SHL: single_res = shift_big ? '0 : (alu_a << alu_b[3:0]);
                OP_SHR: single_res = shift_big ? '0 : (alu_a >> alu_b[3:0]);
                OP_MUL: single_res = '0;
                default: single_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            alu_out  <= '0;
            alu_done <= 1'b0;
            alu_err  <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
`ifdef SEQ_ALU_DIV_EN
            rem      <= '0;
            dq       <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_mod   <= 1'b0;
`endif
        end else begin
            alu_done <= 1'b0;
            alu_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (alu_go) begin
                        if (single_take) begin
                            alu_out  <= single_res;
                            alu_done <= 1'b1;
                            alu_err  <= single_err;
                        end
                        cnt    <= '0;
                        mcand  <= alu_a;
                        mplier <= alu_b;
                        acc    <= '0;
`ifdef SEQ_ALU_DIV_EN
                        rem    <= '0;
                        dq     <= a_mag;
                        dvs    <= b_mag;
                        neg_q  <= alu_a[WIDTH-1] ^ alu_b[WIDTH-1];
                        neg_r  <= alu_a[WIDTH-1];
                        is_mod <= (op_lo == OP_MOD);
`endif
                    end
                end
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        alu_out  <= mul_sum;
                        alu_done <= 1'b1;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    rem <= rem_n;
                    dq  <= dq_n;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    alu_out  <= fix_res;
                    alu_done <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
